// File: rtl/dbb_resp_pkg.sv
// Shared types and constants for the dbb AXI memory responder.
package dbb_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_64B    = 3'b011;

  // Width of the data field carried in the read FIFO (matches the dbb port).
  localparam int unsigned DBB_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD
  } state_e;

  typedef struct packed {
    logic [DBB_DATA_W-1:0] data;
    logic [1:0]            resp;
  } rd_entry_t;

endpackage

// File: rtl/dbb_resp_rd_fifo.sv
// Synchronous read-data FIFO with occupancy count; DEPTH must be a power of 2.
module dbb_resp_rd_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = store[rptr];

  // Entry storage; no reset needed since reads are gated by the count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      store[wptr] <= push_data;
    end
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dbb_axi_mem_responder.sv
// AXI4 slave terminating the NVDLA dbb port onto a req/gnt word memory.
// One transaction at a time, round-robin read/write arbitration, credit-limited
// read FIFO. Optional beat/error counters under `DBB_RESP_PERF_CNT_EN.
module dbb_axi_mem_responder
  import dbb_resp_pkg::*;
#(
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned ID_W          = 8,
  parameter int unsigned MEM_AW        = 20,
  parameter logic [31:0] MEM_BASE      = 32'h0000_0000,
  parameter int unsigned RD_FIFO_DEPTH = 4
) (
  input  logic                  dla_core_clk,
  input  logic                  dla_reset,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ID_W-1:0]       s_awid,
  input  logic [7:0]            s_awlen,
  input  logic [31:0]           s_awaddr,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wlast,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [ID_W-1:0]       s_bid,
  output logic [1:0]            s_bresp,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ID_W-1:0]       s_arid,
  input  logic [7:0]            s_arlen,
  input  logic [31:0]           s_araddr,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ID_W-1:0]       s_rid,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
`ifdef DBB_RESP_PERF_CNT_EN
  ,
  output logic [31:0]           wr_beat_cnt,
  output logic [31:0]           rd_beat_cnt,
  output logic [15:0]           err_cnt
`endif
);

  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned BEAT_SHIFT = $clog2(STRB_W);
  localparam int unsigned CNT_W      = $clog2(RD_FIFO_DEPTH) + 1;
  localparam logic [63:0] WIN_BYTES  = 64'(STRB_W) << MEM_AW;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(RD_FIFO_DEPTH);

  state_e            state;
  state_e            state_nxt;
  logic              rd_pref;
  logic [ID_W-1:0]   id_q;
  logic [7:0]        len_q;
  logic [MEM_AW-1:0] addr_q;
  logic              err_q;
  logic              mis_q;
  logic [8:0]        wr_cnt;
  logic [8:0]        rd_iss;
  logic [8:0]        rd_pop;
  logic [CNT_W-1:0]  out_cnt;

  // Arbitration and request decode
  logic              pick_rd;
  logic              pick_wr;
  logic              accept;
  logic [ID_W-1:0]   a_id;
  logic [7:0]        a_len;
  logic [31:0]       a_addr;
  logic [2:0]        a_size;
  logic [1:0]        a_burst;
  logic [32:0]       a_diff;
  logic [63:0]       a_end;
  logic              a_err;
  logic [MEM_AW-1:0] a_word;

  // Control strobes
  logic              wr_over;
  logic              w_acc;
  logic              credit_ok;
  logic              issue;
  logic              push;
  rd_entry_t         push_entry;
  logic              pop;
  logic              rd_valid;
  rd_entry_t         head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  dbb_resp_rd_fifo #(
    .WIDTH ($bits(rd_entry_t)),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk       (dla_core_clk),
    .rst       (dla_reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Select the winning address channel and decode its window/format errors.
  always_comb begin
    pick_rd = s_arvalid && (!s_awvalid || rd_pref);
    pick_wr = s_awvalid && !pick_rd;
    a_id    = pick_rd ? s_arid    : s_awid;
    a_len   = pick_rd ? s_arlen   : s_awlen;
    a_addr  = pick_rd ? s_araddr  : s_awaddr;
    a_size  = pick_rd ? s_arsize  : s_awsize;
    a_burst = pick_rd ? s_arburst : s_awburst;
    // Borrow out of the 33-bit subtraction flags an address below the window.
    a_diff  = {1'b0, a_addr} - {1'b0, MEM_BASE};
    a_end   = {32'h0, a_diff[31:0]} + (64'({1'b0, a_len} + 9'd1) << BEAT_SHIFT);
    a_err   = (a_burst != BURST_INCR) || (a_size != SIZE_64B) ||
              (a_addr[BEAT_SHIFT-1:0] != '0) || a_diff[32] || (a_end > WIN_BYTES);
    a_word  = a_diff[MEM_AW+BEAT_SHIFT-1:BEAT_SHIFT];
  end

  // FSM state register
  always_ff @(posedge dla_core_clk) begin
    if (dla_reset) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_rd)      state_nxt = ST_RD;
        else if (pick_wr) state_nxt = ST_WR_DATA;
      end
      ST_WR_DATA: if (w_acc && s_wlast)  state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (s_bready)          state_nxt = ST_IDLE;
      ST_RD:      if (pop && s_rlast)    state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: handshakes, memory requests and FIFO strobes per state
  always_comb begin
    s_awready  = 1'b0;
    s_arready  = 1'b0;
    s_wready   = 1'b0;
    s_bvalid   = 1'b0;
    s_bresp    = RESP_OKAY;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    w_acc      = 1'b0;
    credit_ok  = 1'b0;
    issue      = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    rd_valid   = 1'b0;
    pop        = 1'b0;
    wr_over    = (wr_cnt > {1'b0, len_q});
    case (state)
      ST_IDLE: begin
        s_awready = pick_wr;
        s_arready = pick_rd;
      end
      ST_WR_DATA: begin
        mem_we = 1'b1;
        if (err_q || wr_over) begin
          s_wready = 1'b1;
        end else begin
          mem_req  = s_wvalid;
          s_wready = mem_gnt;
        end
        w_acc = s_wvalid && s_wready;
      end
      ST_WR_RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = (err_q || mis_q) ? RESP_SLVERR : RESP_OKAY;
      end
      ST_RD: begin
        credit_ok = (rd_iss <= {1'b0, len_q}) &&
                    (({1'b0, fifo_count} + {1'b0, out_cnt}) < DEPTH_C);
        if (err_q) begin
          // Error bursts still pace zero beats through the credit window.
          issue           = credit_ok;
          push            = credit_ok;
          push_entry.resp = RESP_SLVERR;
        end else begin
          mem_req         = credit_ok;
          issue           = credit_ok && mem_gnt;
          push            = mem_rvalid && (out_cnt != '0);
          push_entry.data = mem_rdata;
          push_entry.resp = RESP_OKAY;
        end
        rd_valid = !fifo_empty;
        pop      = rd_valid && s_rready;
      end
      default: ;
    endcase
  end

  assign accept    = (s_awvalid && s_awready) || (s_arvalid && s_arready);
  assign s_bid     = id_q;
  assign s_rid     = id_q;
  assign s_rvalid  = rd_valid;
  assign s_rlast   = rd_valid && (rd_pop == {1'b0, len_q});
  assign s_rdata   = rd_valid ? head.data : '0;
  assign s_rresp   = rd_valid ? head.resp : RESP_OKAY;
  assign mem_addr  = addr_q;
  assign mem_wdata = s_wdata;
  assign mem_wstrb = s_wstrb;

  // Transaction context, beat counters and arbitration pointer
  always_ff @(posedge dla_core_clk) begin
    if (dla_reset) begin
      rd_pref <= 1'b1;
      id_q    <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      wr_cnt  <= '0;
      rd_iss  <= '0;
      rd_pop  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            id_q   <= a_id;
            len_q  <= a_len;
            addr_q <= a_word;
            err_q  <= a_err;
            mis_q  <= 1'b0;
            wr_cnt <= '0;
            rd_iss <= '0;
            rd_pop <= '0;
            if (s_awvalid && s_arvalid) rd_pref <= !pick_rd;
          end
        end
        ST_WR_DATA: begin
          if (w_acc) begin
            // Saturate so an overlong burst never wraps back into range.
            if (wr_cnt != '1) wr_cnt <= wr_cnt + 9'd1;
            addr_q <= addr_q + MEM_AW'(1);
            if (wr_over || (s_wlast && (wr_cnt < {1'b0, len_q}))) mis_q <= 1'b1;
          end
        end
        ST_RD: begin
          if (issue) begin
            rd_iss <= rd_iss + 9'd1;
            if (!err_q) addr_q <= addr_q + MEM_AW'(1);
          end
          if (pop) rd_pop <= rd_pop + 9'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory reads in flight: up on grant, down on returned data
  always_ff @(posedge dla_core_clk) begin
    if (dla_reset) begin
      out_cnt <= '0;
    end else begin
      case ({issue && !err_q, push && !err_q})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Read data arriving into a full FIFO would be lost.
  assert property (@(posedge dla_core_clk) disable iff (dla_reset) !(mem_rvalid && fifo_full));

`ifdef DBB_RESP_PERF_CNT_EN
  // Free-running event counters for accepted W beats, popped R beats and SLVERRs
  always_ff @(posedge dla_core_clk) begin
    if (dla_reset) begin
      wr_beat_cnt <= '0;
      rd_beat_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      if (w_acc) wr_beat_cnt <= wr_beat_cnt + 32'd1;
      if (pop)   rd_beat_cnt <= rd_beat_cnt + 32'd1;
      if ((s_bvalid && s_bready && (s_bresp == RESP_SLVERR)) ||
          (pop && (s_rresp == RESP_SLVERR)))
        err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dbb_axi_mem_responder.md
Name: dbb_axi_mem_responder

Overview:
- AXI4 slave that terminates the NVDLA dbb master port (aw/w/b/ar/r, 64-bit data, 8-bit IDs) and serves it from a simple single-port word memory interface (req/gnt, in-order read return).
- Used as the memory-side responder in standalone accelerator benches and as a scratchpad backing in the tile.
- Serves one AXI transaction at a time (read or write) with round-robin arbitration; a credit-managed read FIFO absorbs rready backpressure.

Parameters:
- DATA_W, 64, AXI and memory data width; beat size fixed at DATA_W/8 bytes.
- ID_W, 8, AXI ID width.
- MEM_AW, 20, memory word-address width; window size is (DATA_W/8) << MEM_AW bytes.
- MEM_BASE, 32'h0000_0000, byte base address of the window.
- RD_FIFO_DEPTH, 4, read-data FIFO entries (power of 2, minimum 2).

Ports:
- dla_core_clk  in  1  clock.
- dla_reset  in  1  reset.
- s_awvalid/s_awready  in/out  1  write-address handshake.
- s_awid  in  ID_W  write ID.
- s_awlen  in  8  beats-1.
- s_awaddr  in  32  byte address.
- s_awsize  in  3  beat size.
- s_awburst  in  2  burst type.
- s_wvalid/s_wready  in/out  1  write-data handshake.
- s_wdata  in  DATA_W  write data.
- s_wstrb  in  DATA_W/8  byte strobes.
- s_wlast  in  1  last beat.
- s_bvalid/s_bready  out/in  1  write-response handshake.
- s_bid  out  ID_W  response ID.
- s_bresp  out  2  response code.
- s_arvalid/s_arready  in/out  1  read-address handshake; s_arid, s_arlen, s_araddr, s_arsize, s_arburst as for aw.
- s_rvalid/s_rready  out/in  1  read-data handshake.
- s_rid  out  ID_W  read ID.
- s_rdata  out  DATA_W  read data.
- s_rresp  out  2  read response code.
- s_rlast  out  1  last read beat.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  DATA_W  write data.
- mem_wstrb  out  DATA_W/8  byte strobes.
- mem_gnt  in  1  request accepted this cycle (combinational with mem_req).
- mem_rvalid  in  1  read data valid; in order, latency >= 1 cycle after grant.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Interface: one clock, dla_core_clk. Reset dla_reset is synchronous and active-high.
- Reset values: all s_*ready, s_bvalid, s_rvalid, s_rlast and mem_req are 0. s_bresp, s_rresp, s_bid, s_rid and s_rdata are 0. FSM is in IDLE, FIFO is empty, credits are 0, and the arbitration pointer favours read. Reset asserted mid-burst abandons the transaction immediately with no further handshakes.
- FSM states: IDLE, WR_DATA, WR_RESP, RD.
- IDLE arbitration:
  - Only valid request wins.
  - Both valid: the pointer picks, then the pointer flips to the other side.
  - s_awready/s_arready are combinational: 1 only in IDLE for the selected side.
  - On acceptance: latch id, len, word address (addr - MEM_BASE) >> 3, and err.
  - err = burst != INCR(01), or size != 3'b011, or addr[2:0] != 0, or addr < MEM_BASE, or addr - MEM_BASE + (len+1)*8 > window size.
- WR_DATA:
  - No error: mem_req = s_wvalid, mem_we = 1, s_wready = mem_gnt.
  - err set: s_wready = 1 and mem_req = 0.
  - Memory address increments by 1 per accepted beat.
  - Beats beyond len+1 are accepted but not written; they set a mismatch flag.
  - wlast before beat len+1 also sets the mismatch flag.
  - Exit to WR_RESP on the accepted beat with s_wlast = 1.
- WR_RESP:
  - s_bvalid = 1, s_bid = latched id.
  - s_bresp = 2'b10 (SLVERR) if err or mismatch, else 2'b00.
  - Go to IDLE on s_bready.
- RD:
  - Issue mem_req (mem_we = 0) while issued <= len and fifo_count + outstanding < RD_FIFO_DEPTH.
  - Outstanding increments on grant and decrements on mem_rvalid; mem_rvalid pushes mem_rdata into the FIFO.
  - err set: no memory access; push zero data at the same credit-limited rate, tagged SLVERR.
  - s_rvalid = FIFO not empty. s_rdata/s_rresp come from the FIFO head; s_rid = latched id.
  - s_rlast = 1 on beat len+1 popped.
  - After the rlast handshake, go to IDLE.
- Simultaneous FIFO push and pop in the same cycle keeps the count unchanged.
- mem_rvalid with the FIFO full is illegal and flagged by an assertion.
- Beat counters are 9 bits, so len = 255 gives 256 beats with no wrap.

Optional Feature:
- Macro: DBB_RESP_PERF_CNT_EN.
- Defined:
  - Adds outputs wr_beat_cnt[31:0] and rd_beat_cnt[31:0] and err_cnt[15:0].
  - Counts are accepted W beats, popped R beats, and SLVERR responses issued.
  - All reset to 0, increment once per event, and wrap modulo width.
- Undefined: these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package dbb_resp_pkg holds:
  - resp codes RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - BURST_INCR = 2'b01 and SIZE_64B = 3'b011;
  - the FSM state enum;
  - the read-FIFO entry struct {data, resp}.
- One sub-module, dbb_resp_rd_fifo: synchronous FIFO with count output.

Test Plan:
- Write len 0, addr 0x40, data 0xA5A5_0000_0000_0001, wstrb 0xFF -> one mem write at mem_addr 8; bresp 00, bid echoed.
- Write 16 beats at 0x1000, then read back with rready always 1 and memory latency 3 -> 16 beats match, rlast only on beat 16, rresp 00.
- Read 16 beats with RD_FIFO_DEPTH 4 and rready toggling 1-of-4 cycles -> outstanding + count never exceeds 4, no data lost or reordered.
- awvalid and arvalid asserted together, repeatedly -> grants alternate read, write, read; no starvation.
- ar with arburst WRAP (2'b10), len 3 -> no mem_req; 4 beats of zero data with rresp 10; write at addr 0x3 -> bresp 10, memory untouched.
- aw len 3 with wlast on beat 2 -> 2 mem writes, bresp 10. Reset asserted mid-read -> all valids 0 next cycle, and a fresh read afterwards succeeds.
